// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU datapath between NUM_REQ command sources.
// Optional error statistics counter enabled by defining ALU_ARB_ERR_STATS_EN.
module alu_req_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned ID_W = $clog2(NUM_REQ)
`ifdef ALU_ARB_ERR_STATS_EN
   ,
   parameter int unsigned STAT_W = 16
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [6*NUM_REQ-1:0] i_req_cmd,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic                 i_p_error,
   output logic                 o_datain_reg_en,
   output logic                 o_aluin_reg_en,
   output logic                 o_aluout_reg_en,
   output logic [1:0]           o_in_select_a,
   output logic [1:0]           o_in_select_b,
   output logic [3:0]           o_opcode,
   output logic                 o_nvalid_data,
   output logic                 o_rsp_valid,
   output logic [ID_W-1:0]      o_rsp_id,
   output logic                 o_rsp_err
`ifdef ALU_ARB_ERR_STATS_EN
   ,
   input  logic                 i_err_count_clr,
   output logic [STAT_W-1:0]    o_err_count
`endif
);

   typedef enum logic [1:0] {StIdle, StLoad, StExec, StWb} state_e;

   state_e          r_state;
   state_e          w_state_next;
   logic [5:0]      r_cmd;
   logic [5:0]      w_cmd_sel;
   logic [ID_W-1:0] r_id;
   logic [ID_W-1:0] r_last;
   logic [ID_W-1:0] w_winner;
   logic            r_err;
   logic            w_any;
   logic            w_accept;

   // Search starts one past the last grant and wraps around.
   always_comb begin
      w_winner = r_last;
      w_any    = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_any && (i == (32'(r_last) + k) % NUM_REQ) && i_req_valid[i]) begin
               w_winner = ID_W'(i);
               w_any    = 1'b1;
            end
         end
      end
   end

   assign w_accept = !i_rst && w_any && ((r_state == StIdle) || (r_state == StWb));

   always_comb begin
      o_req_ready = '0;
      w_cmd_sel   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_winner == ID_W'(i)) begin
            o_req_ready[i] = w_accept;
            w_cmd_sel      = i_req_cmd[6*i +: 6];
         end
      end
   end

   always_comb begin
      w_state_next    = r_state;
      o_datain_reg_en = 1'b0;
      o_aluin_reg_en  = 1'b0;
      o_aluout_reg_en = 1'b0;
      o_rsp_valid     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StLoad;
         end
         StLoad: begin
            o_datain_reg_en = 1'b1;
            w_state_next    = StExec;
         end
         StExec: begin
            o_aluin_reg_en = 1'b1;
            w_state_next   = StWb;
         end
         StWb: begin
            o_aluout_reg_en = 1'b1;
            o_rsp_valid     = 1'b1;
            w_state_next    = w_accept ? StLoad : StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign o_in_select_a = r_cmd[5:4];
   assign o_in_select_b = r_cmd[3:2];
   assign o_opcode      = {2'b00, r_cmd[1:0]};
   assign o_rsp_id      = r_id;
   assign o_rsp_err     = (r_state == StWb) && r_err;
   assign o_nvalid_data = (r_state == StLoad) && i_p_error &&
                          ((o_in_select_a == 2'd3) || (o_in_select_b == 2'd3));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cmd   <= '0;
         r_id    <= '0;
         r_last  <= ID_W'(NUM_REQ - 1);
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_cmd  <= w_cmd_sel;
            r_id   <= w_winner;
            r_last <= w_winner;
            r_err  <= 1'b0;
         end else if (r_state == StLoad) begin
            r_err <= o_nvalid_data;
         end
      end
   end

`ifdef ALU_ARB_ERR_STATS_EN
   logic [STAT_W-1:0] r_err_count;

   // Clear beats a simultaneous increment; the count saturates at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_err_count_clr) begin
         r_err_count <= '0;
      end else if (o_rsp_err && (r_err_count != '1)) begin
         r_err_count <= r_err_count + 1'b1;
      end
   end

   assign o_err_count = r_err_count;
`endif

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares the single ALU datapath (input muxes, datain/aluin/aluout registers, ALU) between NUM_REQ command sources.
- Grants one request at a time, round-robin, and latches its 6-bit command.
- Sequences the three datapath register enables for that command, then returns a completion pulse tagged with requester id and parity-error status.
- Sits between the command sources and the datapath, replacing a free-running controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ID_W, $clog2(NUM_REQ), width of requester id (derived, not overridden).
- STAT_W, 16, width of the error statistics counter (optional feature only).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  request i presents a command.
- req_cmd  in  6*NUM_REQ  command of requester i in bits [6i+5:6i]; [5:4]=sel A, [3:2]=sel B, [1:0]=op.
- req_ready  out  NUM_REQ  one-hot accept pulse; the command is taken when valid&ready.
- p_error  in  1  parity error on external data, sampled in LOAD.
- datain_reg_en  out  1  datapath input register enable.
- aluin_reg_en  out  1  ALU operand register enable.
- aluout_reg_en  out  1  ALU result register enable.
- in_select_a  out  2  mux A select = latched cmd[5:4].
- in_select_b  out  2  mux B select = latched cmd[3:2].
- opcode  out  4  Operation = {2'b00, latched cmd[1:0]}.
- nvalid_data  out  1  comb: p_error && (in_select_a==3 || in_select_b==3) during LOAD, else 0.
- rsp_valid  out  1  completion pulse.
- rsp_id  out  ID_W  requester of the completed command.
- rsp_err  out  1  command used external data with a parity error.

Behaviour:
- FSM states: IDLE, LOAD, EXEC, WB.
- State outputs:
  - LOAD: datain_reg_en=1.
  - EXEC: aluin_reg_en=1.
  - WB: aluout_reg_en=1, rsp_valid=1.
  - At most one enable is high in any cycle.
- Accept points are IDLE and WB.
  - If any req_valid is high, assert req_ready for exactly the winner (combinational, same cycle).
  - Latch its cmd and id, then go to LOAD.
  - Otherwise WB->IDLE, and IDLE stays in IDLE.
- Transitions: LOAD->EXEC->WB, unconditional.
- Throughput: back-to-back commands run 3 cycles each with no IDLE bubble.
- Round-robin:
  - Search starts at (last_grant+1) mod NUM_REQ.
  - last_grant updates on each accept.
  - Reset value is NUM_REQ-1, so requester 0 wins first.
- A single valid requester is always granted regardless of pointer.
- Error capture: in LOAD, err_q <= nvalid_data. rsp_err=err_q in WB. err_q clears on accept.
- Select/opcode outputs reflect the latched cmd, held stable from LOAD through WB. They keep the last value in IDLE.
- req_cmd/req_valid changes while not accepting are ignored. A requester holds valid until it sees ready.
- Reset values: state=IDLE; all enables, req_ready, rsp_valid, rsp_err=0; latched cmd=0 (selects 0, opcode 0); rsp_id=0; err_q=0.
- rst mid-operation: the next cycle is IDLE, no rsp_valid for the aborted command, and the aborted requester is not acknowledged again.
- rst has priority over accept: no req_ready while rst=1.

Optional Feature:
- Macro ALU_ARB_ERR_STATS_EN.
- With the macro:
  - Adds output err_count [STAT_W-1:0], incremented in each WB cycle with rsp_err=1.
  - Saturates at all-ones and is cleared by rst.
  - Adds input err_count_clr (1), which zeroes the counter. Clear wins over a simultaneous increment.
- Without the macro: neither port exists and no counter logic is present.

Test Plan:
- Reset: hold rst 2 cycles, then req_valid=0 -> state IDLE; all enables, rsp_valid and req_ready 0; selects 0; opcode 0.
- Single command: req_valid=2'b01, cmd0=6'b01_10_11 in IDLE ->
  - req_ready=01 that cycle.
  - datain/aluin/aluout enables high on cycles +1/+2/+3.
  - sel_a=1, sel_b=2, opcode=4'b0011.
  - rsp_valid with rsp_id=0 and rsp_err=0 on cycle +3.
- Contention: both valid continuously -> grants alternate 0,1,0,1. A new accept coincides with each WB, so datain_reg_en recurs every 3 cycles.
- Parity error: cmd=6'b11_00_01 with p_error=1 in LOAD -> nvalid_data=1 in LOAD, rsp_err=1 in WB. With cmd=6'b00_01_00 and p_error=1 -> nvalid_data=0, rsp_err=0.
- Reset mid-op: assert rst during EXEC -> next cycle IDLE, aluout_reg_en never asserted, no rsp_valid. The next request is accepted normally, and requester 0 wins.
- With ALU_ARB_ERR_STATS_EN and STAT_W=2: five error completions -> err_count=3 (saturated). err_count_clr in the same cycle as an error WB -> err_count=0.
